// File: rtl/contador_passo_varredura_m.sv
// contador_passo_varredura_m: up/down position counter with step, saturate/wrap, load, flags, limit pulse and optional ping-pong sweep
// Optional feature macro: CONTADOR_VARREDURA_EN (compiles in varre and the SOBE/DESCE sweep FSM).
// Ports: clock, zera_as (async reset), zera_s (sync clear), carrega/D (sync load), soma/sub (step),
//        varre (sweep enable), Q (position), inicio/meio/fim (position flags), limite (clamp/wrap pulse),
//        sentido (sweep direction, 1 = up).
module contador_passo_varredura_m #(
   parameter int M      = 100,
   parameter int N      = 7,
   parameter int PASSO  = 1,
   parameter int SATURA = 1
) (
   input  logic         clock,
   input  logic         zera_as,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] D,
   input  logic         soma,
   input  logic         sub,
   input  logic         varre,
   output logic [N-1:0] Q,
   output logic         inicio,
   output logic         meio,
   output logic         fim,
   output logic         limite,
   output logic         sentido
);
   localparam logic [N:0] LM   = (N+1)'(M);
   localparam logic [N:0] LTOP = (N+1)'(M-1);
   localparam logic [N:0] LP   = (N+1)'(PASSO);
   localparam logic [N:0] LMID = (N+1)'(M/2-1);
   logic [N-1:0] q_q, q_d;
   logic         lim_q, lim_d, sen_q, sen_d;
   logic [N:0]   qx, up_s, up_sat, up_man, dn_sat, dn_man;
   logic         up_ov, dn_un;
   // one extra bit keeps Q+PASSO and Q+M-PASSO from overflowing
   assign qx     = {1'b0, q_q};
   assign up_s   = qx + LP;
   assign up_ov  = up_s > LTOP;
   assign up_sat = up_ov ? LTOP : up_s;
   assign up_man = !up_ov ? up_s : (SATURA != 0) ? LTOP : up_s - LM;
   assign dn_un  = qx < LP;
   assign dn_sat = dn_un ? '0 : qx - LP;
   assign dn_man = !dn_un ? qx - LP : (SATURA != 0) ? '0 : qx + LM - LP;
`ifdef CONTADOR_VARREDURA_EN
`else
   logic unused_varre;
   assign unused_varre = varre;
`endif
   always_comb begin
      q_d   = q_q;
      lim_d = 1'b0;
      sen_d = sen_q;
      if (zera_s) begin
         q_d   = '0;
         sen_d = 1'b1;
      end else if (carrega)
         q_d = ({1'b0, D} > LTOP) ? LTOP[N-1:0] : D;
      else if (soma && sub)
         q_d = q_q;
      else if (soma) begin
         q_d   = up_man[N-1:0];
         lim_d = up_ov;
      end else if (sub) begin
         q_d   = dn_man[N-1:0];
         lim_d = dn_un;
      end
`ifdef CONTADOR_VARREDURA_EN
      // sweep always saturates; landing on a bound flips direction
      else if (varre) begin
         q_d   = sen_q ? up_sat[N-1:0] : dn_sat[N-1:0];
         lim_d = sen_q ? up_ov : dn_un;
         sen_d = sen_q ? (up_sat != LTOP) : (dn_sat == '0);
      end
`else
      sen_d = 1'b1;
`endif
   end
   always_ff @(posedge clock or posedge zera_as)
      if (zera_as) begin
         q_q   <= '0;
         lim_q <= 1'b0;
         sen_q <= 1'b1;
      end else begin
         q_q   <= q_d;
         lim_q <= lim_d;
         sen_q <= sen_d;
      end
   assign Q       = q_q;
   assign limite  = lim_q;
   assign sentido = sen_q;
   assign inicio  = q_q == '0;
   assign meio    = qx == LMID;
   assign fim     = qx == LTOP;
endmodule
